// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: datapath width, reset vector and the
// 2-bit saturating branch-counter encodings with their update helpers.
package cpu_pkg;

    localparam int unsigned XLEN      = 32;
    localparam logic [31:0] RESET_VEC = 32'h0040_0000;

    localparam logic [1:0] SNT = 2'd0;
    localparam logic [1:0] WNT = 2'd1;
    localparam logic [1:0] WT  = 2'd2;
    localparam logic [1:0] ST  = 2'd3;

    function automatic logic [1:0] sat_inc(input logic [1:0] ctr);
        return (ctr == ST) ? ST : ctr + 2'd1;
    endfunction

    function automatic logic [1:0] sat_dec(input logic [1:0] ctr);
        return (ctr == SNT) ? SNT : ctr - 2'd1;
    endfunction

endpackage

// File: rtl/btb_dm.sv
// Direct-mapped branch target buffer: combinational lookup on the fetch PC,
// registered update from resolved branches.
module btb_dm #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned BTB_ENTRIES = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [XLEN-1:0] lookup_pc,
    input  logic            upd_vld,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_target,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target
);
    import cpu_pkg::*;

    localparam int unsigned IDX_W = $clog2(BTB_ENTRIES);
    localparam int unsigned TAG_W = XLEN - IDX_W - 2;

    logic [BTB_ENTRIES-1:0]            valid_q;
    logic [BTB_ENTRIES-1:0][TAG_W-1:0] tag_q;
    logic [BTB_ENTRIES-1:0][XLEN-1:0]  tgt_q;
    logic [BTB_ENTRIES-1:0][1:0]       ctr_q;

    logic [IDX_W-1:0] lk_idx, up_idx;
    logic [TAG_W-1:0] lk_tag, up_tag;
    logic             lk_hit, up_hit;

    // Byte-offset bits never participate in indexing or tagging.
    logic unused_lsbs;
    assign unused_lsbs = ^{lookup_pc[1:0], upd_pc[1:0]};

    assign lk_idx = lookup_pc[IDX_W+1:2];
    assign lk_tag = lookup_pc[XLEN-1:IDX_W+2];
    assign up_idx = upd_pc[IDX_W+1:2];
    assign up_tag = upd_pc[XLEN-1:IDX_W+2];

    always_comb begin
        lk_hit      = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        up_hit      = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
        pred_taken  = lk_hit && ctr_q[lk_idx][1];
        pred_target = pred_taken ? tgt_q[lk_idx] : '0;
    end

    // Lookup reads the registered arrays, so a same-cycle write is seen next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            tag_q   <= '0;
            tgt_q   <= '0;
            ctr_q   <= '0;
        end else if (en && upd_vld) begin
            if (up_hit) begin
                if (upd_taken) begin
                    ctr_q[up_idx] <= sat_inc(ctr_q[up_idx]);
                    tgt_q[up_idx] <= upd_target;
                end else begin
                    ctr_q[up_idx] <= sat_dec(ctr_q[up_idx]);
                end
            end else if (upd_taken) begin
                valid_q[up_idx] <= 1'b1;
                tag_q[up_idx]   <= up_tag;
                tgt_q[up_idx]   <= upd_target;
                ctr_q[up_idx]   <= WT;
            end
        end
    end

endmodule

// File: rtl/pc_gen_bp.sv
// Fetch PC generator: PC register and next-PC priority mux, with predictions
// supplied by a direct-mapped BTB indexed by the current fetch PC.
module pc_gen_bp #(
    parameter int unsigned       XLEN        = cpu_pkg::XLEN,
    parameter logic [XLEN-1:0]   RESET_VEC   = cpu_pkg::RESET_VEC,
    parameter int unsigned       STEP        = 4,
    parameter int unsigned       BTB_ENTRIES = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            stall,
    input  logic            redirect_vld,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            upd_vld,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_target,
    output logic [XLEN-1:0] pc_out,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target
);

    logic [XLEN-1:0] pc_q, pc_d;

    assign pc_out = pc_q;

    btb_dm #(
        .XLEN        (XLEN),
        .BTB_ENTRIES (BTB_ENTRIES)
    ) u_btb (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .lookup_pc   (pc_q),
        .upd_vld     (upd_vld),
        .upd_pc      (upd_pc),
        .upd_taken   (upd_taken),
        .upd_target  (upd_target),
        .pred_taken  (pred_taken),
        .pred_target (pred_target)
    );

    // Redirect beats stall: a mispredict must flush even a held fetch.
    always_comb begin
        pc_d = pc_q;
        if (!en) begin
            pc_d = pc_q;
        end else if (redirect_vld) begin
            pc_d = redirect_pc;
        end else if (stall) begin
            pc_d = pc_q;
        end else if (pred_taken) begin
            pc_d = pred_target;
        end else begin
            pc_d = pc_q + XLEN'(STEP);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_VEC;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: tb/tb_pc_gen_bp.sv
// Directed bench for pc_gen_bp: reset, sequencing, priority, BTB allocate,
// counter saturation, aliasing and same-cycle update visibility.
module tb_pc_gen_bp;

    logic        clk = 1'b0;
    logic        rst, en, stall, redirect_vld, upd_vld, upd_taken;
    logic [31:0] redirect_pc, upd_pc, upd_target;
    logic [31:0] pc_out, pred_target;
    logic        pred_taken;

    int checks   = 0;
    int failures = 0;

    pc_gen_bp dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .stall        (stall),
        .redirect_vld (redirect_vld),
        .redirect_pc  (redirect_pc),
        .upd_vld      (upd_vld),
        .upd_pc       (upd_pc),
        .upd_taken    (upd_taken),
        .upd_target   (upd_target),
        .pc_out       (pc_out),
        .pred_taken   (pred_taken),
        .pred_target  (pred_target)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stall = 0; redirect_vld = 0; upd_vld = 0; upd_taken = 0;
    endtask

    task automatic pred(input string tag, input logic exp_t, input logic [31:0] exp_tgt);
        chk({tag, "_taken"}, {31'd0, pred_taken}, {31'd0, exp_t});
        chk({tag, "_target"}, pred_target, exp_tgt);
    endtask

    initial begin
        rst = 1; en = 0; stall = 0; redirect_vld = 0; redirect_pc = '0;
        upd_vld = 0; upd_pc = '0; upd_taken = 0; upd_target = '0;
        #2;
        chk("reset_pc", pc_out, 32'h0040_0000);
        pred("reset_pred", 1'b0, 32'h0);
        step();
        rst = 0; en = 1;

        // Sequential fetch
        step(); chk("seq0", pc_out, 32'h0040_0004);
        step(); chk("seq1", pc_out, 32'h0040_0008);
        step(); chk("seq2", pc_out, 32'h0040_000C);

        // Async reset between edges
        rst = 1; #2;
        chk("midrun_reset_pc", pc_out, 32'h0040_0000);
        pred("midrun_reset_pred", 1'b0, 32'h0);
        rst = 0;

        // en=0 freezes even against redirect
        en = 0; redirect_vld = 1; redirect_pc = 32'h0040_0100;
        step(); chk("en0_hold", pc_out, 32'h0040_0000);
        en = 1; idle(); stall = 1;
        step(); chk("stall_hold0", pc_out, 32'h0040_0000);
        step(); chk("stall_hold1", pc_out, 32'h0040_0000);
        redirect_vld = 1; redirect_pc = 32'h0040_0100;
        step(); chk("redirect_over_stall", pc_out, 32'h0040_0100);

        // Allocate 0x08 -> 0x40 while redirecting back to reset vector
        idle();
        upd_vld = 1; upd_taken = 1; upd_pc = 32'h0040_0008; upd_target = 32'h0040_0040;
        redirect_vld = 1; redirect_pc = 32'h0040_0000;
        step(); idle();
        chk("restart", pc_out, 32'h0040_0000);
        pred("restart_pred", 1'b0, 32'h0);
        step(); chk("alloc_f1", pc_out, 32'h0040_0004);
        step(); chk("alloc_f2", pc_out, 32'h0040_0008);
        pred("alloc_pred", 1'b1, 32'h0040_0040);
        step(); chk("alloc_f3", pc_out, 32'h0040_0040);
        pred("at_target_pred", 1'b0, 32'h0);

        // Counter: 2 -> 1 -> 0
        upd_vld = 1; upd_taken = 0; upd_pc = 32'h0040_0008;
        redirect_vld = 1; redirect_pc = 32'h0040_0008;
        step(); redirect_vld = 0; stall = 1;
        chk("ctr1_pc", pc_out, 32'h0040_0008);
        pred("ctr1_pred", 1'b0, 32'h0);
        step(); idle();
        pred("ctr0_pred", 1'b0, 32'h0);
        step(); chk("ctr0_seq", pc_out, 32'h0040_000C);

        // en=0 must also freeze the BTB
        en = 0; upd_vld = 1; upd_taken = 1; upd_pc = 32'h0040_0008; upd_target = 32'h0040_0040;
        step(); step();
        en = 1; idle(); redirect_vld = 1; redirect_pc = 32'h0040_0008;
        step(); idle(); stall = 1;
        pred("en0_btb_frozen", 1'b0, 32'h0);

        // Taken updates: 0 -> 1 (no prediction) -> 2 -> 3 -> 3
        upd_vld = 1; upd_taken = 1; upd_pc = 32'h0040_0008; upd_target = 32'h0040_0040;
        step(); pred("ctr_inc1", 1'b0, 32'h0);
        step(); pred("ctr_inc2", 1'b1, 32'h0040_0040);
        step(); step();
        // Saturated at 3: one not-taken still predicts, second does not
        upd_taken = 0;
        step(); pred("ctr_sat_dec", 1'b1, 32'h0040_0040);
        step(); pred("ctr_dec_to1", 1'b0, 32'h0);
        chk("stall_held_pc", pc_out, 32'h0040_0008);

        // Alias: 0x28 shares index 2 with 0x08 (ctr now 1, still valid)
        idle(); redirect_vld = 1; redirect_pc = 32'h0040_0028;
        step(); idle(); stall = 1;
        chk("alias_pc", pc_out, 32'h0040_0028);
        pred("alias_miss", 1'b0, 32'h0);
        upd_vld = 1; upd_taken = 1; upd_pc = 32'h0040_0028; upd_target = 32'h0040_0080;
        #1; pred("same_cycle_pre", 1'b0, 32'h0);
        step(); idle();
        pred("alias_alloc_hit", 1'b1, 32'h0040_0080);
        step(); chk("alias_follow", pc_out, 32'h0040_0080);
        redirect_vld = 1; redirect_pc = 32'h0040_0008;
        step(); idle(); stall = 1;
        pred("evicted_miss", 1'b0, 32'h0);

        // Misaligned redirect loaded verbatim, then wrap through 2^32
        idle(); redirect_vld = 1; redirect_pc = 32'hFFFF_FFFE;
        step(); idle();
        chk("misaligned_pc", pc_out, 32'hFFFF_FFFE);
        step(); chk("wrap_pc", pc_out, 32'h0000_0002);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
